ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_line_sync.sv | 29 ++
 rtl/ps2_host_tx.sv | 188 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: state encoding, timing conversion, frame and mouse command constants.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_INHIBIT = 3'd1,
      ST_REQ     = 3'd2,
      ST_SHIFT   = 3'd3,
      ST_ACK     = 3'd4
   } state_t;

   // Clock frequency in Hz divided by this gives cycles per microsecond.
   localparam int unsigned US_TO_CYCLES = 1_000_000;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned STOP_EDGE = 10;

   localparam logic [7:0] CMD_RESET  = 8'hFF;
   localparam logic [7:0] CMD_ENABLE = 8'hF4;

   // Converts a duration in microseconds to system clock cycles.
   function automatic int unsigned us_to_cycles(input int unsigned freq_hz, input int unsigned us);
      return (freq_hz / US_TO_CYCLES) * us;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one raw PS/2 line plus falling-edge detect.
// Flops reset to 1, the idle level of a pulled-up open-drain line.
module ps2_line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic line,
   output logic level,
   output logic fall_c
);

   logic meta;
   logic prev;

   // Synchroniser chain and one-cycle history of the synchronised level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta  <= 1'b1;
         level <= 1'b1;
         prev  <= 1'b1;
      end else begin
         meta  <= line;
         level <= meta;
         prev  <= level;
      end
   end

   assign fall_c = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out 8 data bits,
// odd parity and stop, then read the device ACK.
// Optional macro PS2_TX_TIMEOUT_EN adds a watchdog on device clocking.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000,
   parameter int unsigned INHIBIT_US  = 100,
   parameter int unsigned TIMEOUT_US  = 15000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int unsigned INHIBIT_CYCLES = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
   localparam int unsigned INH_W          = $clog2(INHIBIT_CYCLES + 1);

   state_t           state, state_d;
   logic [INH_W-1:0] inh_cnt, inh_d;
   logic [3:0]       bit_cnt, bit_d;
   logic [7:0]       data_q, data_d;
   logic             parity_q, parity_d;
   logic             clk_oe_d, data_oe_d, ready_d, done_d, err_d;
   logic             clk_level_unused;
   logic             clk_fall;
   logic             data_level;
   logic             data_fall_unused;

   ps2_line_sync u_clk_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .line   (ps2_clk_in),
      .level  (clk_level_unused),
      .fall_c (clk_fall)
   );

   ps2_line_sync u_data_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .line   (ps2_data_in),
      .level  (data_level),
      .fall_c (data_fall_unused)
   );

`ifdef PS2_TX_TIMEOUT_EN
   localparam int unsigned TIMEOUT_CYCLES = us_to_cycles(CLK_FREQ_HZ, TIMEOUT_US);
   localparam int unsigned WD_W           = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt, wd_d;

   // Watchdog register: cycles since the last device clock edge while clocking is expected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wd_cnt <= '0;
      else        wd_cnt <= wd_d;
   end
`else
   localparam int unsigned timeout_unused = TIMEOUT_US;
`endif

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         inh_cnt     <= '0;
         bit_cnt     <= '0;
         data_q      <= '0;
         parity_q    <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         tx_ready    <= 1'b1;
         tx_done     <= 1'b0;
         tx_err      <= 1'b0;
      end else begin
         state       <= state_d;
         inh_cnt     <= inh_d;
         bit_cnt     <= bit_d;
         data_q      <= data_d;
         parity_q    <= parity_d;
         ps2_clk_oe  <= clk_oe_d;
         ps2_data_oe <= data_oe_d;
         tx_ready    <= ready_d;
         tx_done     <= done_d;
         tx_err      <= err_d;
      end
   end

   // Next-state and next-output logic; line drives are computed for the state being entered.
   always_comb begin
      state_d   = state;
      inh_d     = inh_cnt;
      bit_d     = bit_cnt;
      data_d    = data_q;
      parity_d  = parity_q;
      clk_oe_d  = ps2_clk_oe;
      data_oe_d = ps2_data_oe;
      done_d    = 1'b0;
      err_d     = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_d      = '0;
`endif

      case (state)
         ST_IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            bit_d     = '0;
            if (tx_valid && tx_ready) begin
               data_d    = tx_data;
               parity_d  = ~^tx_data;
               inh_d     = '0;
               state_d   = ST_INHIBIT;
               clk_oe_d  = 1'b1;
               data_oe_d = (INHIBIT_CYCLES == 1);
            end
         end
         ST_INHIBIT: begin
            if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
               state_d   = ST_REQ;
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b1;
               bit_d     = '0;
            end else begin
               inh_d     = inh_cnt + INH_W'(1);
               data_oe_d = (inh_d == INH_W'(INHIBIT_CYCLES - 1));
            end
         end
         ST_REQ: begin
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (clk_fall) begin
               bit_d = bit_cnt + 4'd1;
               if (bit_cnt < 4'(DATA_BITS)) begin
                  data_oe_d = ~data_q[bit_cnt[2:0]];
               end else if (bit_cnt == 4'(DATA_BITS)) begin
                  data_oe_d = ~parity_q;
               end else begin
                  data_oe_d = 1'b0;
                  state_d   = ST_ACK;
               end
            end
         end
         ST_ACK: begin
            if (clk_fall) begin
               done_d    = ~data_level;
               err_d     = data_level;
               state_d   = ST_IDLE;
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               bit_d     = '0;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            bit_d     = '0;
         end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      if (state == ST_REQ || state == ST_SHIFT || state == ST_ACK) begin
         wd_d = clk_fall ? '0 : wd_cnt + WD_W'(1);
         if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            state_d   = ST_IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            bit_d     = '0;
            done_d    = 1'b0;
            err_d     = 1'b1;
            wd_d      = '0;
         end
      end
`endif

      ready_d = (state_d == ST_IDLE);
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device model.
// Define PS2_TX_TIMEOUT_EN for both RTL and bench to exercise the watchdog.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INHIBIT_EXP = 10000;
   localparam int HALF        = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       ps2_clk_in, ps2_data_in;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       tx_done, tx_err;
   logic       dev_clk, dev_data;

   int n_tests = 0;
   int n_fail  = 0;
   int n_done  = 0;
   int n_err   = 0;
   int n_both  = 0;

   always #5 clk = ~clk;

   // Open-drain wired-AND of host and device on each line.
   assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;

   ps2_host_tx dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .tx_done     (tx_done),
      .tx_err      (tx_err)
   );

   // Pulse counters sampled away from the active edge.
   always @(negedge clk) begin
      if (tx_done) n_done <= n_done + 1;
      if (tx_err)  n_err  <= n_err + 1;
      if (tx_done && tx_err) n_both <= n_both + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Handshake a byte and measure the inhibit phase; optionally keep tx_valid high with 0xAA.
   task automatic start_frame(input logic [7:0] b, input bit aa);
      int inh, inh_dat;
      logic last_dat;
      @(negedge clk);
      check("ready_before_send", 32'(tx_ready), 32'd1);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      if (aa) tx_data = 8'hAA;
      else begin
         tx_valid = 1'b0;
         tx_data  = 8'($urandom);
      end
      inh = 0; inh_dat = 0; last_dat = 1'b0;
      while (ps2_clk_oe === 1'b1 && inh < 2 * INHIBIT_EXP) begin
         inh++;
         if (ps2_data_oe === 1'b1) inh_dat++;
         last_dat = ps2_data_oe;
         @(negedge clk);
      end
      check("inhibit_len", 32'(inh), 32'(INHIBIT_EXP));
      check("inhibit_data_cycles", 32'(inh_dat), 32'd1);
      check("inhibit_data_last", 32'(last_dat), 32'd1);
      check("start_bit", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd1);
      check("busy_not_ready", 32'(tx_ready), 32'd0);
   endtask

   // Full frame with the device model; abort_edge > 0 asserts reset in that edge's low phase.
   task automatic run_frame(input logic [7:0] b, input bit ack, input bit aa, input int abort_edge);
      logic [9:0] got, expv;
      int d0, e0, c, ones;
      ones = $countones(b);
      for (int i = 0; i < 8; i++) expv[i] = ~b[i];
      expv[8] = (ones % 2 == 0) ? 1'b0 : 1'b1;
      expv[9] = 1'b0;
      got = '0;
      d0 = n_done; e0 = n_err;
      start_frame(b, aa);
      repeat (4) @(negedge clk);
      for (int e = 1; e <= 10; e++) begin
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         if (e == abort_edge) begin
            check("abort_pre_data_oe", 32'(ps2_data_oe), 32'd1);
            #2 rst_n = 1'b0;
            #1 check("abort_release", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
            dev_clk  = 1'b1;
            tx_valid = 1'b0;
            repeat (4) @(negedge clk);
            check("abort_no_pulse", 32'((n_done - d0) + (n_err - e0)), 32'd0);
            rst_n = 1'b1;
            @(negedge clk);
            return;
         end
         dev_clk = 1'b1;
         repeat (HALF) @(negedge clk);
         got[e-1] = ps2_data_oe;
         if (e == 10) begin
            dev_data = ack ? 1'b0 : 1'b1;
            tx_valid = 1'b0;
         end
      end
      dev_clk = 1'b0;
      c = 0;
      while (!(tx_done === 1'b1 || tx_err === 1'b1) && c < 4 * HALF) begin
         @(negedge clk);
         c++;
      end
      check("ack_pulse_seen", 32'(c < 4 * HALF), 32'd1);
      @(negedge clk);
      check("after_ack_idle", {28'd0, tx_ready, ps2_clk_oe, ps2_data_oe, tx_done | tx_err}, 32'h8);
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      repeat (HALF) @(negedge clk);
      check("frame_bits", 32'(got), 32'(expv));
      check("done_count", 32'(n_done - d0), 32'(ack));
      check("err_count", 32'(n_err - e0), 32'(!ack));
   endtask

   initial begin
      logic [7:0] rb;
      rst_n    = 1'b0;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", {27'd0, tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_err}, 32'h10);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_after_reset", {27'd0, tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_err}, 32'h10);

      run_frame(CMD_ENABLE, 1'b1, 1'b1, 0);
      run_frame(8'h00, 1'b1, 1'b0, 0);
      rb = 8'($urandom);
      run_frame(rb, 1'b1, 1'b0, 0);
      rb = 8'($urandom);
      run_frame(rb, 1'b0, 1'b0, 0);
      rb = 8'($urandom) & 8'hEF;
      run_frame(rb, 1'b1, 1'b0, 5);
      run_frame(CMD_RESET, 1'b1, 1'b0, 0);

      // Silent device: nothing clocks after the request-to-send.
      begin
         int d0, e0;
         d0 = n_done; e0 = n_err;
         start_frame(8'($urandom), 1'b0);
`ifdef PS2_TX_TIMEOUT_EN
         begin
            int c;
            c = 0;
            while (tx_err !== 1'b1 && c < 1_600_000) begin
               @(negedge clk);
               c++;
            end
            check("timeout_err", 32'(tx_err), 32'd1);
            check("timeout_cycles_ok", 32'(c > 1_400_000), 32'd1);
            @(negedge clk);
            check("timeout_release", {29'd0, tx_ready, ps2_clk_oe, ps2_data_oe}, 32'h4);
            check("timeout_no_done", 32'(n_done - d0), 32'd0);
         end
`else
         repeat (2000) @(negedge clk);
         check("silent_wait_shift", {29'd0, tx_ready, ps2_clk_oe, ps2_data_oe}, 32'h1);
         check("silent_no_pulse", 32'((n_done - d0) + (n_err - e0)), 32'd0);
`endif
      end

      check("never_both_pulses", 32'(n_both), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
